alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the single-cycle datapath; executes the operation selected by a 4-bit control code on operands a and b.
- Produces result, zero flag and signed-overflow flag.
- Inputs are sampled on a clock edge; result and flags are registered, with one cycle of latency and a valid strobe.

Parameters:
- WIDTH, 32, operand/result width in bits (must be ≥ 8).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  operands/aluctl valid this cycle.
- aluctl  in  4  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out  out  WIDTH  registered result.
- zero  out  1  registered: out == 0.
- overflow  out  1  registered signed overflow (ADD/SUB only).
- out_valid  out  1  result/flags valid.

Behaviour:
- Reset: on a rising clk with rst_n=0, out=0, zero=0, overflow=0, out_valid=0. This takes priority over in_valid. Reset mid-operation discards the in-flight result.
- Latency: one cycle. If in_valid=1 at edge N, out/zero/overflow reflect that operation after edge N, and out_valid=1 for that cycle.
- in_valid=0 at an edge: out/zero/overflow hold their previous values; out_valid=0.
- Back-to-back: in_valid=1 every cycle gives a new result every cycle. There is no backpressure.
- Opcodes (aluctl):
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, truncated to WIDTH (carry-out dropped).
  - 0110 SUB: a − b, two's complement, truncated.
  - 0111 EQL: out = 1 if a == b, else 0 (zero-extended).
  - 1100 NOR: ~(a | b).
- Overflow:
  - ADD: 1 iff a[MSB]==b[MSB] and out[MSB]!=a[MSB].
  - SUB: 1 iff a[MSB]!=b[MSB] and out[MSB]!=a[MSB].
  - All other ops: 0.
- zero: computed from the result being registered (1 iff that result is all zeros), for every opcode.
- Undefined opcodes (including shift codes when the feature is out): out=0, zero=1, overflow=0; out_valid behaves normally.
- Unsigned wrap, e.g. 0xFFFFFFFF+1 → 0, zero=1, overflow=0.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined: adds three opcodes, with shift amount b[4:0] (log2(WIDTH) bits); overflow=0 for all three.
  - 1000 SLL: a << shamt.
  - 1001 SRL: logical right shift of a.
  - 1010 SRA: arithmetic right shift of a.
- Undefined: codes 1000/1001/1010 are undefined opcodes, handled as above; no shifter logic is synthesized.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode localparams ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_EQL, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA;
  - the opcode width constant.
- One natural sub-module, alu_addsub: combinational WIDTH-bit adder/subtractor (sub input inverts b and sets carry-in). Outputs sum and signed overflow; shared by ADD, SUB and EQL (EQL uses the sub result == 0).
- Top level holds the result mux, zero detect and output registers.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 → out=0, zero=0, overflow=0, out_valid=0; release → first op result appears one cycle later.
- AND/OR/NOR:
  - AND a=0x0F200603, b=0x0E244201 → 0x0E200201.
  - OR a=0xA0F25221, b=0xA0F83621 → 0xA0FA7621.
  - NOR a=b=0x80F04021 → 0x7F0FBFDE.
  - All with zero=0, overflow=0.
- ADD: a=0x80F04021, b=0x80F02421 → out=0x01E06442, overflow=1. Then a=0xFFFFFFFF, b=1 → out=0, zero=1, overflow=0.
- SUB/EQL:
  - SUB a=b=0x80F04021 → out=0, zero=1, overflow=0.
  - SUB a=0x80000000, b=1 → 0x7FFFFFFF, overflow=1.
  - EQL equal operands → 1.
  - EQL a=0x00027024, b=0x22DA3709 → 0, zero=1.
- Handshake: in_valid pattern 1,0,1 with different ops → out_valid 1,0,1 one cycle delayed; out holds during the gap. Undefined opcode 0011 → out=0, zero=1.
- With ALU_SHIFT_EN:
  - SLL a=1, b=31 → 0x80000000.
  - SRA a=0x80000000, b=4 → 0xF8000000.
  - SRL same → 0x08000000.
  - Without the macro, the same codes → out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU: the opcode field width and the 4-bit opcode
// values carried on aluctl.
// The shift opcodes are always defined here so that decoders and test code
// can name them.  Whether the ALU executes them is decided by the ALU_SHIFT_EN
// macro inside alu.sv.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_CTL_W = 4;

    localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTL_W-1:0] ALU_EQL = 4'b0111;
    localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_CTL_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALU_CTL_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALU_CTL_W-1:0] ALU_SRA = 4'b1010;

endpackage

// File: rtl/alu_addsub.sv
// -----------------------------------------------------------------------------
// alu_addsub
// Combinational WIDTH-bit adder/subtractor.  A single adder serves ADD, SUB
// and EQL.  Subtraction is done as a + ~b + 1.
//
// Ports:
//   a, b      in   WIDTH  operands
//   sub       in   1      1 = a - b, 0 = a + b
//   sum       out  WIDTH  truncated result (the carry-out is dropped)
//   overflow  out  1      signed overflow of the selected operation
// -----------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {{(WIDTH-1){1'b0}}, sub};

    // Signed overflow happens when both effective addends share a sign and the
    // sum has the other sign.  For SUB the effective addend is ~b.  The check
    // a[MSB] == ~b[MSB] is therefore the same as a[MSB] != b[MSB].
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Integer ALU with registered outputs and one cycle of latency.
// When in_valid is high at a clock edge, the operation selected by aluctl is
// applied to a and b.  The result and its flags are registered, and out_valid
// is raised for the following cycle.  When in_valid is low, the result and
// flags keep their previous values.
//
// Optional feature macro ALU_SHIFT_EN adds SLL, SRL and SRA, with the shift
// amount taken from b[$clog2(WIDTH)-1:0].  When the macro is not defined,
// those codes are treated as undefined opcodes and no shifter is built.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      aluctl/a/b valid this cycle
//   aluctl     in   4      operation select
//   a, b       in   WIDTH  operands
//   out        out  WIDTH  registered result
//   zero       out  1      registered (out == 0)
//   overflow   out  1      registered signed overflow (ADD/SUB only)
//   out_valid  out  1      out/zero/overflow updated by the previous edge
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [ALU_CTL_W-1:0] aluctl,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     out,
    output logic                 zero,
    output logic                 overflow,
    output logic                 out_valid
);

    logic             sub_sel;
    logic [WIDTH-1:0] sum;
    logic             addsub_ovf;
    logic [WIDTH-1:0] result_next;
    logic             overflow_next;

    logic [WIDTH-1:0] out_reg;
    logic             zero_reg;
    logic             overflow_reg;
    logic             out_valid_reg;

    // EQL shares the subtractor: the operands are equal exactly when a - b == 0.
    assign sub_sel = (aluctl == ALU_SUB) || (aluctl == ALU_EQL);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (sub_sel),
        .sum      (sum),
        .overflow (addsub_ovf)
    );

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];
`endif

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (aluctl)
            ALU_AND: result_next = a & b;
            ALU_OR:  result_next = a | b;
            ALU_NOR: result_next = ~(a | b);
            ALU_ADD: begin
                result_next   = sum;
                overflow_next = addsub_ovf;
            end
            ALU_SUB: begin
                result_next   = sum;
                overflow_next = addsub_ovf;
            end
            ALU_EQL: result_next = {{(WIDTH-1){1'b0}}, (sum == '0)};
`ifdef ALU_SHIFT_EN
            ALU_SLL: result_next = a << shamt;
            ALU_SRL: result_next = a >> shamt;
            ALU_SRA: result_next = $unsigned($signed(a) >>> shamt);
`endif
            default: result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg       <= '0;
            zero_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_reg      <= result_next;
                zero_reg     <= (result_next == '0);
                overflow_reg <= overflow_next;
            end
        end
    end

    assign out       = out_reg;
    assign zero      = zero_reg;
    assign overflow  = overflow_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu
// Self-checking bench for alu.  A behavioural model, written with plain
// integer arithmetic, tracks the expected registered outputs.  A negedge
// process compares the DUT against this model on every cycle.  Directed
// vectors also check hand-computed literal results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [3:0]   aluctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         zero;
    logic         overflow;
    logic         out_valid;

    int checks = 0;
    int fails  = 0;

    // Model state
    logic [W-1:0] m_out;
    logic         m_zero;
    logic         m_ovf;
    logic         m_valid;
    logic         m_live = 1'b0;

    always #5 clk = ~clk;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .aluctl    (aluctl),
        .a         (a),
        .b         (b),
        .out       (out),
        .zero      (zero),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    // Returns {overflow, result}.  Overflow is found by comparing the exact
    // signed result against the representable range.
    function automatic logic [W:0] model_op(input logic [3:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        longint       s;
        logic [W-1:0] r;
        logic         ov;
        r  = '0;
        ov = 1'b0;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin
                s  = longint'($signed(x)) + longint'($signed(y));
                r  = s[W-1:0];
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0110: begin
                s  = longint'($signed(x)) - longint'($signed(y));
                r  = s[W-1:0];
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = (x == y) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_EN
            4'b1000: r = x << y[4:0];
            4'b1001: r = x >> y[4:0];
            4'b1010: r = $signed(x) >>> y[4:0];
`endif
            default: r = '0;
        endcase
        return {ov, r};
    endfunction

    always @(posedge clk) begin
        logic [W:0] res;
        m_live <= 1'b1;
        if (!rst_n) begin
            m_out   <= '0;
            m_zero  <= 1'b0;
            m_ovf   <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                res    = model_op(aluctl, a, b);
                m_out  <= res[W-1:0];
                m_zero <= (res[W-1:0] == '0);
                m_ovf  <= res[W];
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_live) begin
            check("model.out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("model.out", out, m_out);
            check("model.zero", {31'd0, zero}, {31'd0, m_zero});
            check("model.overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    // Issue one operation and check the literal result one cycle later.
    task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] e_out, input logic e_zero,
                         input logic e_ovf);
        in_valid = 1'b1;
        aluctl   = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        $display("op %s ctl=%04b a=0x%08h b=0x%08h -> out=0x%08h z=%0b ov=%0b v=%0b",
                 name, op, x, y, out, zero, overflow, out_valid);
        check({name, ".out"}, out, e_out);
        check({name, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
        check({name, ".ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
        check({name, ".valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        aluctl   = ALU_ADD;
        a        = 32'd5;
        b        = 32'd3;

        // Reset wins over in_valid
        repeat (2) @(posedge clk);
        #1;
        $display("reset: out=0x%08h z=%0b ov=%0b v=%0b", out, zero, overflow, out_valid);
        check("reset.out", out, 32'd0);
        check("reset.zero", {31'd0, zero}, 32'd0);
        check("reset.ovf", {31'd0, overflow}, 32'd0);
        check("reset.valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        do_op("first_add", ALU_ADD, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
        do_op("and", ALU_AND, 32'h0F200603, 32'h0E244201, 32'h0E200201, 1'b0, 1'b0);
        do_op("or", ALU_OR, 32'hA0F25221, 32'hA0F83621, 32'hA0FA7621, 1'b0, 1'b0);
        do_op("nor", ALU_NOR, 32'h80F04021, 32'h80F04021, 32'h7F0FBFDE, 1'b0, 1'b0);
        do_op("add_ovf", ALU_ADD, 32'h80F04021, 32'h80F02421, 32'h01E06442, 1'b0, 1'b1);
        do_op("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0);
        do_op("add_posovf", ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
        do_op("sub_eq", ALU_SUB, 32'h80F04021, 32'h80F04021, 32'h0, 1'b1, 1'b0);
        do_op("sub_ovf", ALU_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
        do_op("sub_neg", ALU_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0);
        do_op("eql_eq", ALU_EQL, 32'h12345678, 32'h12345678, 32'd1, 1'b0, 1'b0);
        do_op("eql_ne", ALU_EQL, 32'h00027024, 32'h22DA3709, 32'd0, 1'b1, 1'b0);

        // Handshake gap: the output holds and out_valid drops
        do_op("hs_and", ALU_AND, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        aluctl   = ALU_OR;
        a        = 32'h11111111;
        b        = 32'h22222222;
        @(posedge clk);
        #1;
        $display("gap: out=0x%08h v=%0b", out, out_valid);
        check("gap.valid", {31'd0, out_valid}, 32'd0);
        check("gap.hold", out, 32'h0F0F0000);
        do_op("hs_or", ALU_OR, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0);

        do_op("undef", 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
        do_op("sll", ALU_SLL, 32'h1, 32'd31, 32'h80000000, 1'b0, 1'b0);
        do_op("sra", ALU_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
        do_op("srl", ALU_SRL, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0);
`else
        do_op("sll_off", ALU_SLL, 32'h1, 32'd31, 32'h0, 1'b1, 1'b0);
        do_op("sra_off", ALU_SRA, 32'h80000000, 32'd4, 32'h0, 1'b1, 1'b0);
        do_op("srl_off", ALU_SRL, 32'h80000000, 32'd4, 32'h0, 1'b1, 1'b0);
`endif

        // A reset during an operation discards it
        do_op("pre_rst", ALU_OR, 32'h00F00000, 32'h0000000F, 32'h00F0000F, 1'b0, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        aluctl   = ALU_ADD;
        a        = 32'd100;
        b        = 32'd200;
        @(posedge clk);
        #1;
        $display("mid reset: out=0x%08h v=%0b", out, out_valid);
        check("midrst.out", out, 32'd0);
        check("midrst.valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        do_op("post_rst", ALU_ADD, 32'd100, 32'd200, 32'd300, 1'b0, 1'b0);

        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
